// File: rtl/cpu7_exu_irf_sb_if.sv
// Decode/writeback-side bundle for the cpu7 integer register file with load scoreboard.
// The master side is the pipeline; the slave side is the register file.
interface cpu7_exu_irf_sb_if #(
    parameter int unsigned GRLEN = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned NRD   = 2,
    parameter int unsigned NWR   = 2,
    parameter int unsigned CW    = 6
);
    logic [NRD*AW-1:0]    rd_addr_d;
    logic [NRD-1:0]       rd_use_d;
    logic [NRD*GRLEN-1:0] rd_data_d;
    logic [AW-1:0]        dst_d;
    logic                 dst_use_d;
    logic [NWR-1:0]       wen_w;
    logic [NWR*AW-1:0]    waddr_w;
    logic [NWR*GRLEN-1:0] wdata_w;
    logic                 ld_issue_e;
    logic [AW-1:0]        ld_rd_e;
    logic                 ld_ret_m;
    logic [AW-1:0]        ld_ret_rd_m;
    logic                 stall_d;
    logic [CW-1:0]        pend_cnt;

    modport master (
        output rd_addr_d, rd_use_d, dst_d, dst_use_d, wen_w, waddr_w, wdata_w,
               ld_issue_e, ld_rd_e, ld_ret_m, ld_ret_rd_m,
        input  rd_data_d, stall_d, pend_cnt
    );

    modport slave (
        input  rd_addr_d, rd_use_d, dst_d, dst_use_d, wen_w, waddr_w, wdata_w,
               ld_issue_e, ld_rd_e, ld_ret_m, ld_ret_rd_m,
        output rd_data_d, stall_d, pend_cnt
    );
endinterface

// File: rtl/cpu7_exu_irf_sb.sv
// Integer register file with write-through bypass and a pending-load scoreboard that
// raises the D-stage stall on load-use and write-after-write hazards.
module cpu7_exu_irf_sb #(
    parameter int unsigned GRLEN = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned NRD   = 2,
    parameter int unsigned NWR   = 2,
    parameter int unsigned CW    = 6
) (
    input logic             clk,
    input logic             resetn,
    cpu7_exu_irf_sb_if.slave bus
);
    localparam int unsigned NREG = 1 << AW;

    logic [GRLEN-1:0]     regs [NREG];
    logic [NREG-1:0]      pend;
    logic [NREG-1:0]      pend_next;
    logic [CW-1:0]        cnt_next;
    logic [CW-1:0]        pend_cnt_q;
    logic [NRD*GRLEN-1:0] rd_data;
    logic                 raw_any;
    logic                 waw;
    logic                 stall;

    // Later ports are applied last, so the highest-index writer wins on a collision.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < NREG; k++) regs[k] <= '0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (bus.wen_w[j] && bus.waddr_w[j*AW +: AW] != '0) begin
                    regs[bus.waddr_w[j*AW +: AW]] <= bus.wdata_w[j*GRLEN +: GRLEN];
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NRD; i++) begin
            if (resetn && bus.rd_addr_d[i*AW +: AW] != '0) begin
                rd_data[i*GRLEN +: GRLEN] = regs[bus.rd_addr_d[i*AW +: AW]];
                for (int j = 0; j < NWR; j++) begin
                    if (bus.wen_w[j] && bus.waddr_w[j*AW +: AW] == bus.rd_addr_d[i*AW +: AW]) begin
                        rd_data[i*GRLEN +: GRLEN] = bus.wdata_w[j*GRLEN +: GRLEN];
                    end
                end
            end
        end
    end

    // Issue is applied after return so a new load to the same register keeps ownership.
    always_comb begin
        pend_next = pend;
        if (bus.ld_ret_m) pend_next[bus.ld_ret_rd_m] = 1'b0;
        if (bus.ld_issue_e) pend_next[bus.ld_rd_e] = 1'b1;
        pend_next[0] = 1'b0;
        cnt_next = '0;
        for (int k = 0; k < NREG; k++) cnt_next = cnt_next + CW'(pend_next[k]);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend       <= '0;
            pend_cnt_q <= '0;
        end else begin
            pend       <= pend_next;
            pend_cnt_q <= cnt_next;
        end
    end

    always_comb begin
        raw_any = 1'b0;
        for (int i = 0; i < NRD; i++) begin
            if (bus.rd_use_d[i] && bus.rd_addr_d[i*AW +: AW] != '0 &&
                (pend[bus.rd_addr_d[i*AW +: AW]] ||
                 (bus.ld_issue_e && bus.ld_rd_e == bus.rd_addr_d[i*AW +: AW])) &&
                !(bus.ld_ret_m && bus.ld_ret_rd_m == bus.rd_addr_d[i*AW +: AW] &&
                  !(bus.ld_issue_e && bus.ld_rd_e == bus.rd_addr_d[i*AW +: AW]))) begin
                raw_any = 1'b1;
            end
        end
        waw = bus.dst_use_d && bus.dst_d != '0 &&
              (pend[bus.dst_d] || (bus.ld_issue_e && bus.ld_rd_e == bus.dst_d));
        stall = resetn && (raw_any || waw);
    end

    assign bus.rd_data_d = rd_data;
    assign bus.stall_d   = stall;
    assign bus.pend_cnt  = pend_cnt_q;
endmodule

// File: tb/tb_cpu7_exu_irf_sb.sv
// Directed bench for cpu7_exu_irf_sb: a per-cycle model check plus literal expectations.
module tb_cpu7_exu_irf_sb;
    logic clk;
    logic resetn;
    logic check_en;
    int   checks;
    int   errors;

    cpu7_exu_irf_sb_if bus ();

    cpu7_exu_irf_sb dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural model: register contents and the set of registers owed load data.
    logic [31:0] m_regs [32];
    bit          m_pend [32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Is register r still owed load data once this cycle's issue/return take effect?
    function automatic bit owed_after(input int r);
        if (r == 0) return 1'b0;
        if (bus.ld_issue_e && int'(bus.ld_rd_e) == r) return 1'b1;
        if (bus.ld_ret_m && int'(bus.ld_ret_rd_m) == r) return 1'b0;
        return m_pend[r];
    endfunction

    // Newest value of register a, counting this cycle's writes.
    function automatic logic [31:0] exp_read(input int a);
        logic [31:0] v;
        if (!resetn || a == 0) return 32'h0;
        v = m_regs[a];
        for (int j = 0; j < 2; j++)
            if (bus.wen_w[j] && int'(bus.waddr_w[j*5 +: 5]) == a) v = bus.wdata_w[j*32 +: 32];
        return v;
    endfunction

    function automatic logic exp_stall();
        int d;
        if (!resetn) return 1'b0;
        for (int i = 0; i < 2; i++)
            if (bus.rd_use_d[i] && owed_after(int'(bus.rd_addr_d[i*5 +: 5]))) return 1'b1;
        d = int'(bus.dst_d);
        if (bus.dst_use_d && d != 0 && (m_pend[d] || (bus.ld_issue_e && int'(bus.ld_rd_e) == d)))
            return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] exp_cnt();
        int n;
        n = 0;
        for (int r = 0; r < 32; r++) n += int'(m_pend[r]);
        return 32'(n);
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int r = 0; r < 32; r++) begin
                m_regs[r] <= 32'h0;
                m_pend[r] <= 1'b0;
            end
        end else begin
            for (int j = 0; j < 2; j++)
                if (bus.wen_w[j] && bus.waddr_w[j*5 +: 5] != 5'd0)
                    m_regs[bus.waddr_w[j*5 +: 5]] <= bus.wdata_w[j*32 +: 32];
            for (int r = 0; r < 32; r++) m_pend[r] <= owed_after(r);
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            for (int i = 0; i < 2; i++)
                chk("model rd_data", bus.rd_data_d[i*32 +: 32], exp_read(int'(bus.rd_addr_d[i*5 +: 5])));
            chk("model stall_d", {31'b0, bus.stall_d}, {31'b0, exp_stall()});
            chk("model pend_cnt", {26'b0, bus.pend_cnt}, exp_cnt());
        end
    end

    task automatic idle();
        bus.rd_addr_d   = '0;
        bus.rd_use_d    = '0;
        bus.dst_d       = '0;
        bus.dst_use_d   = 1'b0;
        bus.wen_w       = '0;
        bus.waddr_w     = '0;
        bus.wdata_w     = '0;
        bus.ld_issue_e  = 1'b0;
        bus.ld_rd_e     = '0;
        bus.ld_ret_m    = 1'b0;
        bus.ld_ret_rd_m = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic rd(input int port, input logic [4:0] a, input logic use_it);
        bus.rd_addr_d[port*5 +: 5] = a;
        bus.rd_use_d[port]         = use_it;
    endtask

    task automatic wr(input int port, input logic [4:0] a, input logic [31:0] d);
        bus.wen_w[port]             = 1'b1;
        bus.waddr_w[port*5 +: 5]    = a;
        bus.wdata_w[port*32 +: 32]  = d;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        check_en = 1'b0;
        resetn   = 1'b1;
        idle();
        #2 resetn = 1'b0;
        #1 check_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        // Reset state: every register reads zero, nothing pending.
        for (int a = 0; a < 32; a += 2) begin
            rd(0, 5'(a), 1'b1);
            rd(1, 5'(a + 1), 1'b1);
            #1;
            chk("reset rd0", bus.rd_data_d[31:0], 32'h0);
            chk("reset rd1", bus.rd_data_d[63:32], 32'h0);
            chk("reset stall", {31'b0, bus.stall_d}, 32'h0);
            chk("reset pend_cnt", {26'b0, bus.pend_cnt}, 32'h0);
            next_cycle();
        end

        // Preload with distinct port patterns.
        wr(0, 5'd1, 32'h1111_0001); wr(1, 5'd2, 32'h2222_0002); next_cycle();
        wr(1, 5'd3, 32'h3333_0003); rd(0, 5'd1, 1'b1); rd(1, 5'd2, 1'b1);
        #1;
        chk("preload r1", bus.rd_data_d[31:0], 32'h1111_0001);
        chk("preload r2", bus.rd_data_d[63:32], 32'h2222_0002);
        next_cycle();

        // Both ports write r5: higher port wins, both for bypass and storage.
        wr(0, 5'd5, 32'h11); wr(1, 5'd5, 32'h22); rd(0, 5'd5, 1'b1); rd(1, 5'd3, 1'b1);
        #1;
        chk("dual write bypass r5", bus.rd_data_d[31:0], 32'h22);
        chk("r3 stored", bus.rd_data_d[63:32], 32'h3333_0003);
        next_cycle();
        rd(0, 5'd5, 1'b1);
        #1;
        chk("dual write stored r5", bus.rd_data_d[31:0], 32'h22);
        next_cycle();

        // Load-use on r7, then same-cycle release with returned data.
        bus.ld_issue_e = 1'b1; bus.ld_rd_e = 5'd7; rd(0, 5'd7, 1'b1);
        #1;
        chk("issue r7 stall", {31'b0, bus.stall_d}, 32'h1);
        next_cycle();
        bus.ld_ret_m = 1'b1; bus.ld_ret_rd_m = 5'd7; wr(0, 5'd7, 32'hABCD); rd(1, 5'd7, 1'b1);
        #1;
        chk("ret r7 stall", {31'b0, bus.stall_d}, 32'h0);
        chk("ret r7 data", bus.rd_data_d[63:32], 32'hABCD);
        chk("r7 pending cnt", {26'b0, bus.pend_cnt}, 32'h1);
        next_cycle();
        #1;
        chk("r7 released cnt", {26'b0, bus.pend_cnt}, 32'h0);

        // r0 is hardwired: writes and load issues to it are ignored.
        wr(1, 5'd0, 32'hFF); bus.ld_issue_e = 1'b1; bus.ld_rd_e = 5'd0; rd(0, 5'd0, 1'b1);
        bus.dst_d = 5'd0; bus.dst_use_d = 1'b1;
        #1;
        chk("r0 read", bus.rd_data_d[31:0], 32'h0);
        chk("r0 stall", {31'b0, bus.stall_d}, 32'h0);
        next_cycle();
        rd(0, 5'd0, 1'b1);
        #1;
        chk("r0 pend_cnt", {26'b0, bus.pend_cnt}, 32'h0);
        chk("r0 after write", bus.rd_data_d[31:0], 32'h0);
        next_cycle();

        // r9: return and re-issue in the same cycle keeps it pending.
        bus.ld_issue_e = 1'b1; bus.ld_rd_e = 5'd9; next_cycle();
        bus.ld_issue_e = 1'b1; bus.ld_rd_e = 5'd9; bus.ld_ret_m = 1'b1; bus.ld_ret_rd_m = 5'd9;
        bus.dst_d = 5'd9; bus.dst_use_d = 1'b1; rd(0, 5'd9, 1'b0);
        #1;
        chk("r9 waw stall", {31'b0, bus.stall_d}, 32'h1);
        next_cycle();
        bus.ld_ret_m = 1'b1; bus.ld_ret_rd_m = 5'd9; rd(1, 5'd9, 1'b1);
        #1;
        chk("r9 still pending", {26'b0, bus.pend_cnt}, 32'h1);
        chk("r9 return release", {31'b0, bus.stall_d}, 32'h0);
        next_cycle();
        // Stray return to a non-pending register changes nothing.
        bus.ld_ret_m = 1'b1; bus.ld_ret_rd_m = 5'd12;
        next_cycle();
        #1;
        chk("stray return cnt", {26'b0, bus.pend_cnt}, 32'h0);

        // Pend r3 and r4, then assert reset between clock edges.
        bus.ld_issue_e = 1'b1; bus.ld_rd_e = 5'd3; next_cycle();
        bus.ld_issue_e = 1'b1; bus.ld_rd_e = 5'd4; wr(0, 5'd3, 32'h33); next_cycle();
        rd(1, 5'd3, 1'b1);
        #1;
        chk("r3 raw stall", {31'b0, bus.stall_d}, 32'h1);
        chk("r3 r4 pend_cnt", {26'b0, bus.pend_cnt}, 32'h2);
        chk("r3 value", bus.rd_data_d[63:32], 32'h33);
        bus.ld_issue_e = 1'b1; bus.ld_rd_e = 5'd5; wr(1, 5'd3, 32'h99);
        resetn = 1'b0;
        #1;
        chk("reset pend_cnt mid", {26'b0, bus.pend_cnt}, 32'h0);
        chk("reset stall mid", {31'b0, bus.stall_d}, 32'h0);
        chk("reset r3 mid", bus.rd_data_d[63:32], 32'h0);
        @(posedge clk);
        #1;
        chk("held reset r3", bus.rd_data_d[63:32], 32'h0);
        @(negedge clk);
        #1 resetn = 1'b1;
        idle();
        rd(1, 5'd3, 1'b1); rd(0, 5'd5, 1'b1);
        #1;
        chk("post reset r3", bus.rd_data_d[63:32], 32'h0);
        chk("post reset r5", bus.rd_data_d[31:0], 32'h0);
        chk("post reset cnt", {26'b0, bus.pend_cnt}, 32'h0);
        next_cycle();
        next_cycle();

        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
